// File: rtl/alu_seq_pkg.sv
// Shared opcode, state and carry helpers for the nibble-serial ALU controller.
package alu_seq_pkg;

  localparam logic [2:0] OP_CLR    = 3'b000;
  localparam logic [2:0] OP_BMA    = 3'b001;
  localparam logic [2:0] OP_AMB    = 3'b010;
  localparam logic [2:0] OP_ADD    = 3'b011;
  localparam logic [2:0] OP_XOR    = 3'b100;
  localparam logic [2:0] OP_OR     = 3'b101;
  localparam logic [2:0] OP_AND    = 3'b110;
  localparam logic [2:0] OP_PRESET = 3'b111;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ops whose final carry is meaningful.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_BMA) || (op == OP_AMB) || (op == OP_ADD);
  endfunction

  // Subtracts run as A + ~B + 1 inside the slice, so they start with carry set.
  function automatic logic init_carry(input logic [2:0] op);
    return (op == OP_BMA) || (op == OP_AMB);
  endfunction

endpackage

// File: rtl/alu_nibble_seq_if.sv
// Request/response bundle between the sequencer and the nibble-serial ALU.
interface alu_nibble_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, cout, zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, cout, zero
  );
endinterface

// File: rtl/alu_nibble_seq.sv
// Time-multiplexes one 4-bit 74381-style slice to compute a WIDTH-bit ALU op,
// least-significant nibble first, rippling carry from the slice's G/P.
module alu_nibble_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_nibble_seq_if.slave bus,
  output logic [2:0]  slice_s,
  output logic [3:0]  slice_a,
  output logic [3:0]  slice_b,
  output logic        slice_cin,
  input  logic [3:0]  slice_f,
  input  logic        slice_g,
  input  logic        slice_p
);

  localparam int unsigned NIB   = WIDTH / NIB_W;
  localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic             carry_q;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             zero_q;
  logic             done_q;
  logic             busy_q;

  logic             carry_nxt;
  logic [WIDTH-1:0] result_nxt;

  // Slice drive comes straight from the latched operands and current index.
  assign slice_s   = op_q;
  assign slice_a   = a_q[NIB_W*idx_q +: NIB_W];
  assign slice_b   = b_q[NIB_W*idx_q +: NIB_W];
  assign slice_cin = carry_q;

  // Carry into the next nibble from the slice's generate/propagate.
  assign carry_nxt = slice_g | (slice_p & carry_q);

  // Result with the current nibble replaced by the slice output.
  always_comb begin
    result_nxt = result_q;
    result_nxt[NIB_W*idx_q +: NIB_W] = slice_f;
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.zero   = zero_q;

  // Control FSM with datapath registers; reset discards any partial result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            op_q    <= bus.op;
            idx_q   <= '0;
            carry_q <= init_carry(bus.op);
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          result_q <= result_nxt;
          carry_q  <= carry_nxt;
          if (idx_q == IDX_LAST) begin
            idx_q   <= '0;
            cout_q  <= is_arith(op_q) & carry_nxt;
            zero_q  <= (result_nxt == '0);
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Bench for alu_nibble_seq: behavioural 74381 slice, full-width reference model, scoreboard queue.
module tb_alu_nibble_seq;
  import alu_seq_pkg::*;

  localparam int unsigned W   = 16;
  localparam int unsigned NIB = W / 4;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         z;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] slice_s;
  logic [3:0] slice_a;
  logic [3:0] slice_b;
  logic       slice_cin;
  logic [3:0] slice_f;
  logic       slice_g;
  logic       slice_p;

  alu_nibble_seq_if #(.WIDTH(W)) bus ();

  alu_nibble_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .slice_s   (slice_s),
    .slice_a   (slice_a),
    .slice_b   (slice_b),
    .slice_cin (slice_cin),
    .slice_f   (slice_f),
    .slice_g   (slice_g),
    .slice_p   (slice_p)
  );

  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bus.done === 1'b1) done_cnt++;

  // Behavioural 74381 slice: subtracts as x + ~y + cin.
  logic [3:0] sx, sy;
  logic [4:0] s0;
  always_comb begin
    sx = slice_a;
    sy = slice_b;
    if (slice_s == OP_BMA) begin sx = slice_b; sy = ~slice_a; end
    if (slice_s == OP_AMB) begin sx = slice_a; sy = ~slice_b; end
    s0 = {1'b0, sx} + {1'b0, sy};
    slice_g = s0[4];
    slice_p = &(sx | sy);
    case (slice_s)
      OP_CLR:                 slice_f = 4'h0;
      OP_BMA, OP_AMB, OP_ADD: slice_f = sx + sy + {3'b000, slice_cin};
      OP_XOR:                 slice_f = slice_a ^ slice_b;
      OP_OR:                  slice_f = slice_a | slice_b;
      OP_AND:                 slice_f = slice_a & slice_b;
      default:                slice_f = 4'hF;
    endcase
  end

  function automatic exp_t ref_calc(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic [W:0] s;
    s   = '0;
    e.r = '0;
    e.c = 1'b0;
    case (o)
      OP_CLR:    e.r = '0;
      OP_BMA:    begin s = {1'b0, y} + {1'b0, ~x} + (W+1)'(1); e.r = s[W-1:0]; e.c = s[W]; end
      OP_AMB:    begin s = {1'b0, x} + {1'b0, ~y} + (W+1)'(1); e.r = s[W-1:0]; e.c = s[W]; end
      OP_ADD:    begin s = {1'b0, x} + {1'b0, y}; e.r = s[W-1:0]; e.c = s[W]; end
      OP_XOR:    e.r = x ^ y;
      OP_OR:     e.r = x | y;
      OP_AND:    e.r = x & y;
      default:   e.r = '1;
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  // Drive a one-cycle start at a negedge and record the expected outcome; returns
  // at the negedge after the accepting edge with operands scrambled.
  task automatic issue_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    sb.push_back(ref_calc(o, x, y));
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = ~o;
    bus.a     = ~x;
    bus.b     = W'($urandom);
  endtask

  // Bounded wait for done; cyc counts negedges since the accepting edge.
  task automatic wait_done(output int cyc, output bit ok);
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    ok = (bus.done === 1'b1);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    checks++; if (bus.done !== 1'b0)   begin errors++; $display("FAIL reset_done got=%b want=0", bus.done); end
    checks++; if (bus.result !== '0)   begin errors++; $display("FAIL reset_result got=%h want=0", bus.result); end
    checks++; if ({bus.cout, bus.zero} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b want=00", {bus.cout, bus.zero}); end
    checks++; if ({slice_s, slice_a, slice_b, slice_cin} !== '0) begin errors++; $display("FAIL reset_slice got=%h want=0", {slice_s, slice_a, slice_b, slice_cin}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Table-driven single ops, each checked for latency, result and flags.
  task automatic test_ops(input string name, input logic [2:0] ops[], input logic [W-1:0] as[], input logic [W-1:0] bs[]);
    int cyc;
    bit ok;
    exp_t e;
    for (int i = 0; i < ops.size(); i++) begin
      issue_op(ops[i], as[i], bs[i]);
      checks++;
      if (slice_s !== ops[i] || slice_cin !== init_carry(ops[i]))
        begin errors++; $display("FAIL %s_first_nibble[%0d] got s=%b cin=%b want s=%b cin=%b", name, i, slice_s, slice_cin, ops[i], init_carry(ops[i])); end
      wait_done(cyc, ok);
      e = sb.pop_front();
      checks++;
      if (!ok) begin errors++; $display("FAIL %s_timeout[%0d] got no done want done", name, i); end
      else begin
        checks++; if (cyc !== NIB + 1) begin errors++; $display("FAIL %s_latency[%0d] got=%0d want=%0d", name, i, cyc, NIB + 1); end
        checks++; if (bus.result !== e.r) begin errors++; $display("FAIL %s_result[%0d] got=%h want=%h", name, i, bus.result, e.r); end
        checks++; if (bus.cout !== e.c)   begin errors++; $display("FAIL %s_cout[%0d] got=%b want=%b", name, i, bus.cout, e.c); end
        checks++; if (bus.zero !== e.z)   begin errors++; $display("FAIL %s_zero[%0d] got=%b want=%b", name, i, bus.zero, e.z); end
        @(negedge clk);
        checks++; if ({bus.done, bus.busy} !== 2'b00 || bus.result !== e.r)
          begin errors++; $display("FAIL %s_after_done[%0d] got done=%b busy=%b res=%h want 0 0 %h", name, i, bus.done, bus.busy, bus.result, e.r); end
      end
    end
  endtask

  // Start pulses during RUN are ignored; a start right after done is accepted.
  task automatic test_ignore_busy();
    int cyc;
    bit ok;
    int base;
    exp_t e;
    base = done_cnt;
    issue_op(OP_ADD, 16'h1234, 16'h0FCD);
    bus.start = 1'b1;
    bus.op    = OP_XOR;
    bus.a     = 16'hAAAA;
    bus.b     = 16'h5555;
    repeat (2) @(negedge clk);
    bus.start = 1'b0;
    wait_done(cyc, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || cyc + 2 !== NIB + 1 || bus.result !== e.r || bus.cout !== e.c)
      begin errors++; $display("FAIL busy_ignore got ok=%b cyc=%0d res=%h c=%b want 1 %0d %h %b", ok, cyc + 2, bus.result, bus.cout, NIB + 1, e.r, e.c); end
    @(negedge clk);
    issue_op(OP_AMB, 16'h0005, 16'h0007);
    wait_done(cyc, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || cyc !== NIB + 1 || bus.result !== e.r || bus.cout !== e.c || bus.zero !== e.z)
      begin errors++; $display("FAIL back_to_back got ok=%b cyc=%0d res=%h c=%b z=%b want 1 %0d %h %b %b", ok, cyc, bus.result, bus.cout, bus.zero, NIB + 1, e.r, e.c, e.z); end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt !== base + 2) begin errors++; $display("FAIL busy_done_count got=%0d want=%0d", done_cnt - base, 2); end
  endtask

  // Reset mid-RUN discards the partial result and produces no done.
  task automatic test_reset_mid_run();
    int cyc;
    bit ok;
    int base;
    exp_t e;
    issue_op(OP_ADD, 16'h1111, 16'h2222);
    repeat (2) @(negedge clk);
    base  = done_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b want=0", bus.busy); end
    checks++; if (bus.result !== '0) begin errors++; $display("FAIL midrst_result got=%h want=0", bus.result); end
    repeat (8) @(negedge clk);
    checks++; if (done_cnt !== base) begin errors++; $display("FAIL midrst_no_done got=%0d want=0", done_cnt - base); end
    issue_op(OP_BMA, 16'h0003, 16'h000A);
    wait_done(cyc, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || bus.result !== e.r || bus.cout !== e.c)
      begin errors++; $display("FAIL midrst_recover got ok=%b res=%h c=%b want 1 %h %b", ok, bus.result, bus.cout, e.r, e.c); end
    @(negedge clk);
  endtask

  initial begin
    logic [2:0]   ops[];
    logic [W-1:0] as[];
    logic [W-1:0] bs[];
    test_reset();

    ops = '{OP_ADD, OP_ADD};
    as  = '{16'h1234, 16'hFFFF};
    bs  = '{16'h0FCD, 16'h0001};
    test_ops("add", ops, as, bs);

    ops = '{OP_AMB, OP_BMA, OP_AMB};
    as  = '{16'h0005, 16'h0003, 16'h8000};
    bs  = '{16'h0007, 16'h000A, 16'h8000};
    test_ops("sub", ops, as, bs);

    ops = '{OP_XOR, OP_PRESET, OP_CLR, OP_OR, OP_AND};
    as  = '{16'hF0F0, 16'h1234, 16'hFFFF, 16'h0F00, 16'h3C3C};
    bs  = '{16'hFF00, 16'h5678, 16'hFFFF, 16'h00F1, 16'h0FF0};
    test_ops("logic", ops, as, bs);

    ops = new[8];
    as  = new[8];
    bs  = new[8];
    for (int i = 0; i < 8; i++) begin
      ops[i] = 3'($urandom_range(0, 7));
      as[i]  = W'($urandom);
      bs[i]  = W'($urandom);
    end
    test_ops("rand", ops, as, bs);

    test_ignore_busy();
    test_reset_mid_run();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
